// File: rtl/nibble_uart_tx.sv
// Nibble serial transmitter: start, 4 data bits LSB first, parity, stop.
// Valid/ready upstream handshake; each bit is held for CLKS_PER_BIT clocks.
module nibble_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_nibble,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_parity
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_shift;
    logic [1:0]    r_idx;
    logic          r_tx;
    logic          r_ready;
    logic          r_busy;
    logic          r_parity;

    logic w_last;
    logic w_par;

    assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_par  = PARITY_ODD ? ~^i_nibble : ^i_nibble;

    // Handshake: a nibble transfers on a rising edge where i_valid and o_ready are both high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && r_ready) begin
                        r_shift  <= i_nibble;
                        r_parity <= w_par;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                default: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                        // o_tx is loaded with the level of the upcoming bit so it stays registered.
                        case (r_state)
                            S_START: begin
                                r_state <= S_DATA;
                                r_idx   <= '0;
                                r_tx    <= r_shift[0];
                            end
                            S_DATA: begin
                                r_shift <= {1'b0, r_shift[3:1]};
                                r_idx   <= r_idx + 2'd1;
                                if (r_idx == 2'd3) begin
                                    r_state <= S_PARITY;
                                    r_tx    <= r_parity;
                                end else begin
                                    r_tx    <= r_shift[1];
                                end
                            end
                            S_PARITY: begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                            S_STOP: begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_tx     = r_tx;
    assign o_busy   = r_busy;
    assign o_parity = r_parity;
endmodule

// File: tb/tb_nibble_uart_tx.sv
// Bench for nibble_uart_tx: one instance at 4 clocks/bit even parity,
// one at 1 clock/bit odd parity; line bits checked against a queue of expected levels.
module tb_nibble_uart_tx;
  logic       clk;
  logic       rst_n;
  logic [3:0] nib0, nib1;
  logic       val0, val1;
  logic       rdy0, tx0, busy0, par0;
  logic       rdy1, tx1, busy1, par1;

  logic [0:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  nibble_uart_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_nibble(nib0), .i_valid(val0),
    .o_ready(rdy0), .o_tx(tx0), .o_busy(busy0), .o_parity(par0)
  );

  nibble_uart_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_nibble(nib1), .i_valid(val1),
    .o_ready(rdy1), .o_tx(tx1), .o_busy(busy1), .o_parity(par1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected frame levels: start, d0..d3, parity, stop
  task automatic push_frame(input logic [3:0] nib, input logic odd);
    logic p;
    p = odd ? ~^nib : ^nib;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(nib[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Called just before the accept edge with val0/nib0 set.
  // Randomises nib0 mid-frame and pulses valid with 4'h7 while busy.
  task automatic frame0(input logic [3:0] nib, input logic hold, input logic [3:0] next_nib);
    logic [0:0] e;
    logic       p;
    p = ^nib;
    push_frame(nib, 1'b0);
    @(negedge clk);
    chk("d0_busy_after_accept", {3'b0, busy0}, 4'd1);
    chk("d0_ready_after_accept", {3'b0, rdy0}, 4'd0);
    chk("d0_parity_after_accept", {3'b0, par0}, {3'b0, p});
    val0 = hold;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("d0_tx_bit%0d_cyc%0d", k, c), {3'b0, tx0}, {3'b0, e});
        nib0 = 4'($urandom_range(0, 15));
        val0 = hold;
        if (k == 2 && c == 0) begin
          val0 = 1'b1;
          nib0 = 4'h7;
        end
        if (k == 6 && c == 3) nib0 = next_nib;
        @(negedge clk);
      end
    end
    chk("d0_ready_back", {3'b0, rdy0}, 4'd1);
    chk("d0_busy_clear", {3'b0, busy0}, 4'd0);
    chk("d0_idle_tx", {3'b0, tx0}, 4'd1);
    chk("d0_parity_held", {3'b0, par0}, {3'b0, p});
  endtask

  task automatic frame1(input logic [3:0] nib);
    logic [0:0] e;
    nib1 = nib;
    val1 = 1'b1;
    push_frame(nib, 1'b1);
    @(negedge clk);
    val1 = 1'b0;
    nib1 = ~nib;
    chk("d1_parity", {3'b0, par1}, {3'b0, ~^nib});
    chk("d1_busy", {3'b0, busy1}, 4'd1);
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("d1_tx_bit%0d", k), {3'b0, tx1}, {3'b0, e});
      @(negedge clk);
    end
    chk("d1_ready_back", {3'b0, rdy1}, 4'd1);
    chk("d1_idle_tx", {3'b0, tx1}, 4'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    val0 = 1'b0; nib0 = 4'h0;
    val1 = 1'b0; nib1 = 4'h0;

    // reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_tx", {3'b0, tx0}, 4'd1);
    chk("rst_ready", {3'b0, rdy0}, 4'd1);
    chk("rst_busy", {3'b0, busy0}, 4'd0);
    chk("rst_parity", {3'b0, par0}, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_tx0", {3'b0, tx0}, 4'd1);
      chk("idle_tx1", {3'b0, tx1}, 4'd1);
      chk("idle_ready1", {3'b0, rdy1}, 4'd1);
    end

    // even parity frame, 4 clocks/bit
    val0 = 1'b1; nib0 = 4'b1011;
    frame0(4'b1011, 1'b0, 4'h0);
    @(negedge clk);
    chk("no_extra_frame_busy", {3'b0, busy0}, 4'd0);
    chk("no_extra_frame_tx", {3'b0, tx0}, 4'd1);

    // odd parity, 1 clock/bit
    frame1(4'b0000);
    frame1(4'b1011);
    frame1(4'($urandom_range(0, 15)));

    // back-to-back with valid held high
    val0 = 1'b1; nib0 = 4'h5;
    frame0(4'h5, 1'b1, 4'hF);
    frame0(4'hF, 1'b0, 4'h0);
    @(negedge clk);
    chk("b2b_end_busy", {3'b0, busy0}, 4'd0);

    // reset mid-frame during DATA
    val0 = 1'b1; nib0 = 4'hA;
    @(negedge clk);
    val0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {3'b0, busy0}, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {3'b0, tx0}, 4'd1);
    chk("async_rst_ready", {3'b0, rdy0}, 4'd1);
    chk("async_rst_busy", {3'b0, busy0}, 4'd0);
    chk("async_rst_parity", {3'b0, par0}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle_tx", {3'b0, tx0}, 4'd1);
      chk("post_rst_idle_busy", {3'b0, busy0}, 4'd0);
    end
    val0 = 1'b1; nib0 = 4'h3;
    frame0(4'h3, 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
